// File: rtl/cmos_video_pkg.sv
// Shared types and widths for the parallel-CMOS video source.
// The phase timer reload is "cycles - 1", with a requested length of 0 clamped to one cycle.
package cmos_video_pkg;

    localparam int TIMER_W = 32;
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FV_LEAD,
        ST_LINE,
        ST_LINE_GAP,
        ST_FV_TRAIL,
        ST_FRAME_GAP
    } state_t;

    // A phase of N cycles loads N-1; a phase of 0 cycles is stretched to one cycle.
    function automatic logic [TIMER_W-1:0] phase_load(input logic [TIMER_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - TIMER_W'(1);
    endfunction

endpackage

// File: rtl/cmos_phase_timer.sv
// Loadable down-counter that times every phase of the video sequence.
// done is high while the count is zero, so a load of N-1 holds a phase for N cycles.
module cmos_phase_timer
    import cmos_video_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/cmos_video_source.sv
// Parallel-CMOS camera source: a start pulse emits num_frames frames of fv/lv/data
// with programmable line counts, pixel counts and blanking gaps.
module cmos_video_source
    import cmos_video_pkg::*;
#(
    parameter int num_frames        = 1,
    parameter int num_lines         = 4,
    parameter int num_pixels        = 1000,
    parameter int cmos_fv_h_to_lv_h = 800,
    parameter int cmos_lv_l_to_lv_h = 800,
    parameter int cmos_lv_l_to_fv_l = 800,
    parameter int cmos_fv_l_to_fv_h = 800,
    parameter int dwidth            = 10,
    parameter int long_even_line_en = 0
) (
    input  logic              refclk_i,
    input  logic              reset,
    input  logic              start_i,
    output logic              cmos_active_o,
    output logic              cmos_fv,
    output logic              cmos_lv,
    output logic [dwidth-1:0] cmos_data
);

    localparam logic [TIMER_W-1:0] SHORT_LEN = TIMER_W'(num_pixels);
    localparam logic [TIMER_W-1:0] LONG_LEN  =
        (long_even_line_en != 0) ? TIMER_W'(2 * num_pixels) : SHORT_LEN;

    state_t               state;
    logic [COUNT_W-1:0]   frames_left;
    logic [COUNT_W-1:0]   lines_left;
    logic                 line_even;
    logic                 t_load;
    logic [TIMER_W-1:0]   t_val;
    logic                 t_done;

    cmos_phase_timer u_timer (
        .clk      (refclk_i),
        .rst      (reset),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // Timer reloads on the same edge the FSM enters the next phase.
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        case (state)
            ST_IDLE: begin
                t_load = start_i;
                t_val  = phase_load(TIMER_W'(cmos_fv_h_to_lv_h));
            end
            ST_FV_LEAD: begin
                t_load = t_done;
                t_val  = phase_load(SHORT_LEN);
            end
            ST_LINE: begin
                t_load = t_done;
                t_val  = (lines_left == COUNT_W'(1)) ? phase_load(TIMER_W'(cmos_lv_l_to_fv_l))
                                                     : phase_load(TIMER_W'(cmos_lv_l_to_lv_h));
            end
            ST_LINE_GAP: begin
                t_load = t_done;
                t_val  = line_even ? phase_load(SHORT_LEN) : phase_load(LONG_LEN);
            end
            ST_FV_TRAIL: begin
                t_load = t_done && (frames_left != COUNT_W'(1));
                t_val  = phase_load(TIMER_W'(cmos_fv_l_to_fv_h));
            end
            ST_FRAME_GAP: begin
                t_load = t_done;
                t_val  = phase_load(TIMER_W'(cmos_fv_h_to_lv_h));
            end
            default: begin
                t_load = 1'b0;
                t_val  = '0;
            end
        endcase
    end

    always_ff @(posedge refclk_i or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            frames_left   <= '0;
            lines_left    <= '0;
            line_even     <= 1'b0;
            cmos_active_o <= 1'b0;
            cmos_fv       <= 1'b0;
            cmos_lv       <= 1'b0;
            cmos_data     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        cmos_active_o <= 1'b1;
                        cmos_fv       <= 1'b1;
                        frames_left   <= COUNT_W'(num_frames);
                        lines_left    <= COUNT_W'(num_lines);
                        line_even     <= 1'b0;
                        state         <= ST_FV_LEAD;
                    end
                end
                ST_FV_LEAD: begin
                    if (t_done) begin
                        cmos_lv   <= 1'b1;
                        cmos_data <= '0;
                        state     <= ST_LINE;
                    end
                end
                ST_LINE: begin
                    if (t_done) begin
                        cmos_lv    <= 1'b0;
                        cmos_data  <= '0;
                        lines_left <= lines_left - COUNT_W'(1);
                        state      <= (lines_left == COUNT_W'(1)) ? ST_FV_TRAIL : ST_LINE_GAP;
                    end else begin
                        cmos_data <= cmos_data + dwidth'(1);
                    end
                end
                ST_LINE_GAP: begin
                    if (t_done) begin
                        cmos_lv   <= 1'b1;
                        cmos_data <= '0;
                        line_even <= ~line_even;
                        state     <= ST_LINE;
                    end
                end
                ST_FV_TRAIL: begin
                    if (t_done) begin
                        cmos_fv     <= 1'b0;
                        frames_left <= frames_left - COUNT_W'(1);
                        if (frames_left == COUNT_W'(1)) begin
                            cmos_active_o <= 1'b0;
                            state         <= ST_IDLE;
                        end else begin
                            state <= ST_FRAME_GAP;
                        end
                    end
                end
                ST_FRAME_GAP: begin
                    if (t_done) begin
                        cmos_fv    <= 1'b1;
                        lines_left <= COUNT_W'(num_lines);
                        line_even  <= 1'b0;
                        state      <= ST_FV_LEAD;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmos_video_source.sv
// Directed bench for cmos_video_source: five configurations, each checked cycle by cycle
// against an expected waveform queue plus hand-computed pulse totals.
module tb_cmos_video_source;

    localparam int W = 27;

    logic       clk;
    logic       reset;
    logic [4:0] st;
    logic [4:0] act;
    logic [4:0] fv;
    logic [4:0] lv;
    logic [9:0] d0, d1, d2, d4;
    logic [7:0] d3;

    logic [W-1:0] exp_q[$];
    int total;
    int bad;
    int fv_hi, lv_hi, lv_rises, act_hi, max_d;
    logic prev_lv;

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    cmos_video_source #(.num_frames(1), .num_lines(4), .num_pixels(8),
        .cmos_fv_h_to_lv_h(3), .cmos_lv_l_to_lv_h(3), .cmos_lv_l_to_fv_l(3),
        .cmos_fv_l_to_fv_h(3), .dwidth(10), .long_even_line_en(0)) u0 (
        .refclk_i(clk), .reset(reset), .start_i(st[0]), .cmos_active_o(act[0]),
        .cmos_fv(fv[0]), .cmos_lv(lv[0]), .cmos_data(d0));

    cmos_video_source #(.num_frames(2), .num_lines(4), .num_pixels(8),
        .cmos_fv_h_to_lv_h(3), .cmos_lv_l_to_lv_h(3), .cmos_lv_l_to_fv_l(3),
        .cmos_fv_l_to_fv_h(3), .dwidth(10), .long_even_line_en(0)) u1 (
        .refclk_i(clk), .reset(reset), .start_i(st[1]), .cmos_active_o(act[1]),
        .cmos_fv(fv[1]), .cmos_lv(lv[1]), .cmos_data(d1));

    cmos_video_source #(.num_frames(1), .num_lines(4), .num_pixels(8),
        .cmos_fv_h_to_lv_h(3), .cmos_lv_l_to_lv_h(3), .cmos_lv_l_to_fv_l(3),
        .cmos_fv_l_to_fv_h(3), .dwidth(10), .long_even_line_en(1)) u2 (
        .refclk_i(clk), .reset(reset), .start_i(st[2]), .cmos_active_o(act[2]),
        .cmos_fv(fv[2]), .cmos_lv(lv[2]), .cmos_data(d2));

    cmos_video_source #(.num_frames(1), .num_lines(1), .num_pixels(300),
        .cmos_fv_h_to_lv_h(3), .cmos_lv_l_to_lv_h(3), .cmos_lv_l_to_fv_l(3),
        .cmos_fv_l_to_fv_h(3), .dwidth(8), .long_even_line_en(0)) u3 (
        .refclk_i(clk), .reset(reset), .start_i(st[3]), .cmos_active_o(act[3]),
        .cmos_fv(fv[3]), .cmos_lv(lv[3]), .cmos_data(d3));

    cmos_video_source #(.num_frames(2), .num_lines(2), .num_pixels(4),
        .cmos_fv_h_to_lv_h(0), .cmos_lv_l_to_lv_h(0), .cmos_lv_l_to_fv_l(0),
        .cmos_fv_l_to_fv_h(0), .dwidth(10), .long_even_line_en(0)) u4 (
        .refclk_i(clk), .reset(reset), .start_i(st[4]), .cmos_active_o(act[4]),
        .cmos_fv(fv[4]), .cmos_lv(lv[4]), .cmos_data(d4));

    // ---------------- helpers ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic a, input logic f, input logic l, input int d);
        return {a, f, l, 24'(d)};
    endfunction

    function automatic logic [W-1:0] obs(input int idx);
        logic [23:0] d;
        d = '0;
        case (idx)
            0: d = 24'(d0);
            1: d = 24'(d1);
            2: d = 24'(d2);
            3: d = 24'(d3);
            4: d = 24'(d4);
            default: d = '0;
        endcase
        return {act[idx], fv[idx], lv[idx], d};
    endfunction

    function automatic int g(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    // Expected waveform, one word per cycle starting with the cycle after start is sampled.
    task automatic push_burst(input int frames, input int lines, input int px, input int lead,
                              input int lgap, input int trail, input int fgap,
                              input bit long_en, input int dw);
        int m;
        int len;
        m = (dw >= 24) ? 32'hFF_FFFF : ((1 << dw) - 1);
        for (int f = 0; f < frames; f++) begin
            for (int c = 0; c < g(lead); c++) exp_q.push_back(mk(1, 1, 0, 0));
            for (int l = 1; l <= lines; l++) begin
                len = (long_en && (l % 2 == 0)) ? 2 * px : px;
                for (int p = 0; p < len; p++) exp_q.push_back(mk(1, 1, 1, p & m));
                if (l < lines)
                    for (int c = 0; c < g(lgap); c++) exp_q.push_back(mk(1, 1, 0, 0));
            end
            for (int c = 0; c < g(trail); c++) exp_q.push_back(mk(1, 1, 0, 0));
            if (f < frames - 1)
                for (int c = 0; c < g(fgap); c++) exp_q.push_back(mk(1, 0, 0, 0));
        end
        for (int c = 0; c < 3; c++) exp_q.push_back(mk(0, 0, 0, 0));
    endtask

    // Pulse start on one DUT, then compare every cycle against exp_q; busy_a/busy_b re-pulse start mid-burst.
    task automatic run_stream(input int idx, input int busy_a, input int busy_b);
        logic [W-1:0] w_got;
        logic [W-1:0] w_exp;
        int n;
        n = 0;
        fv_hi = 0; lv_hi = 0; lv_rises = 0; act_hi = 0; max_d = 0; prev_lv = 1'b0;
        @(negedge clk);
        st[idx] = 1'b1;
        @(negedge clk);
        st[idx] = 1'b0;
        while (exp_q.size() > 0) begin
            w_exp = exp_q.pop_front();
            w_got = obs(idx);
            check_val($sformatf("u%0d_cyc%0d", idx, n), 32'(w_got), 32'(w_exp));
            if (w_got[25]) fv_hi++;
            if (w_got[24]) lv_hi++;
            if (w_got[26]) act_hi++;
            if (w_got[24] && !prev_lv) lv_rises++;
            if (int'(w_got[23:0]) > max_d) max_d = int'(w_got[23:0]);
            prev_lv = w_got[24];
            n++;
            st[idx] = (n == busy_a || n == busy_b);
            @(negedge clk);
        end
        st[idx] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic found;
        total = 0;
        bad = 0;
        st = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) check_val($sformatf("rst_state_u%0d", i), 32'(obs(i)), 32'd0);
        reset = 1'b0;

        // Single frame: fv 47 cycles, four 8-cycle lines.
        push_burst(1, 4, 8, 3, 3, 3, 3, 0, 10);
        run_stream(0, -1, -1);
        check_val("u0_fv_hi", fv_hi, 47);
        check_val("u0_lv_hi", lv_hi, 32);
        check_val("u0_lv_rises", lv_rises, 4);
        check_val("u0_act_hi", act_hi, 47);
        check_val("u0_max_d", max_d, 7);

        // Asynchronous reset in the middle of a line.
        @(negedge clk);
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (lv[0]) found = 1'b1;
            else @(negedge clk);
        end
        check_val("u0_lv_seen", 32'(found), 32'd1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_val("u0_async_rst", 32'(obs(0)), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        push_burst(1, 4, 8, 3, 3, 3, 3, 0, 10);
        run_stream(0, -1, -1);
        check_val("u0_post_rst_fv_hi", fv_hi, 47);
        check_val("u0_post_rst_lv_hi", lv_hi, 32);

        // Two frames with start re-pulsed mid-line and during the frame gap.
        push_burst(2, 4, 8, 3, 3, 3, 3, 0, 10);
        run_stream(1, 20, 48);
        check_val("u1_fv_hi", fv_hi, 94);
        check_val("u1_act_hi", act_hi, 97);
        check_val("u1_lv_rises", lv_rises, 8);

        // Long even lines: 8, 16, 8, 16.
        push_burst(1, 4, 8, 3, 3, 3, 3, 1, 10);
        run_stream(2, -1, -1);
        check_val("u2_lv_hi", lv_hi, 48);
        check_val("u2_fv_hi", fv_hi, 63);
        check_val("u2_max_d", max_d, 15);

        // 8-bit data over a 300-pixel line wraps after 255.
        push_burst(1, 1, 300, 3, 3, 3, 3, 0, 8);
        run_stream(3, -1, -1);
        check_val("u3_lv_hi", lv_hi, 300);
        check_val("u3_fv_hi", fv_hi, 306);
        check_val("u3_max_d", max_d, 255);

        // Zero gaps become single-cycle gaps.
        push_burst(2, 2, 4, 0, 0, 0, 0, 0, 10);
        run_stream(4, -1, -1);
        check_val("u4_fv_hi", fv_hi, 22);
        check_val("u4_lv_hi", lv_hi, 16);
        check_val("u4_lv_rises", lv_rises, 4);
        check_val("u4_act_hi", act_hi, 23);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
